// File: rtl/procesor_pkg.sv
// ---------------------------------------------------------------------------
// procesor_pkg
// Shared definitions for the processor pipeline: default bus widths used by
// the program ROM, the fetch stage and the decoder, plus the fetch FSM state
// type.
// ---------------------------------------------------------------------------
package procesor_pkg;

    // Default program address / instruction word widths.
    localparam int DOMYSLNA_ADDR_WIDTH = 8;
    localparam int DOMYSLNA_DATA_WIDTH = 16;

    // Fetch FSM: RUN fetches, HALT freezes the PC (jumps still load it).
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } stan_pobierania_t;

endpackage

// File: rtl/licznik_pc.sv
// ---------------------------------------------------------------------------
// licznik_pc
// Program counter register: load (jump) has priority over increment,
// otherwise hold. Increment wraps modulo 2^ADDR_WIDTH without any flag.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset, loads RESET_ADDR
//   laduj        load cel into the PC
//   cel          load value (jump target)
//   inkrementuj  advance the PC by one
//   pc           current PC value
// ---------------------------------------------------------------------------
module licznik_pc
    import procesor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DOMYSLNA_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  laduj,
    input  logic [ADDR_WIDTH-1:0] cel,
    input  logic                  inkrementuj,
    output logic [ADDR_WIDTH-1:0] pc
);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else if (laduj) begin
            pc <= cel;
        end else if (inkrementuj) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/pobieranie_rozkazow.sv
// ---------------------------------------------------------------------------
// pobieranie_rozkazow
// Instruction fetch stage. Drives the program ROM address from the PC,
// captures the ROM word into the instruction register and offers it to
// decode over a valid/ready handshake. Supports jump with flush and halt.
//
// Build option: define POBIERANIE_SKOK_WZGL_EN for PC-relative jumps
// (target = pc_ir + signed skok_adr); otherwise skok_adr is absolute.
//
// Ports:
//   clk, rst_n   clock / synchronous active-low reset
//   rom_a        program ROM address (= PC, combinational)
//   rom_d        program ROM data
//   skok         jump request pulse, skok_adr = target or offset
//   stop         halt request (level)
//   ir, pc_ir    captured instruction and the address it came from
//   ir_valid     ir holds an instruction not yet accepted
//   ir_ready     decode accepts ir this cycle
//   zatrzymany   fetch is halted
// ---------------------------------------------------------------------------
module pobieranie_rozkazow
    import procesor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DOMYSLNA_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DOMYSLNA_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0] rom_d,
    input  logic                  skok,
    input  logic [ADDR_WIDTH-1:0] skok_adr,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] pc_ir,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic                  zatrzymany
);

    stan_pobierania_t      stan;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] cel;
    logic                  wolny;
    logic                  pobierz;

    // The instruction slot can take a new word when empty or being drained.
    assign wolny   = !ir_valid || ir_ready;
    // A jump or a halt request suppresses the capture in the same cycle.
    assign pobierz = (stan == RUN) && !stop && !skok && wolny;

`ifdef POBIERANIE_SKOK_WZGL_EN
    // Operands share one width, so the sign extension of the offset is
    // implicit in the modulo-2^ADDR_WIDTH wraparound of the sum.
    assign cel = pc_ir + skok_adr;
`else
    assign cel = skok_adr;
`endif

    licznik_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_licznik_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .laduj       (skok),
        .cel         (cel),
        .inkrementuj (pobierz),
        .pc          (pc)
    );

    assign rom_a = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stan       <= RUN;
            zatrzymany <= 1'b0;
            ir         <= '0;
            pc_ir      <= '0;
            ir_valid   <= 1'b0;
        end else begin
            // The halt request alone decides the next state, in any state.
            stan       <= stop ? HALT : RUN;
            zatrzymany <= stop;

            if (skok) begin
                // Flush: the word in ir is from the abandoned path.
                ir_valid <= 1'b0;
            end else if (pobierz) begin
                ir       <= rom_d;
                pc_ir    <= pc;
                ir_valid <= 1'b1;
            end else if (ir_ready) begin
                // No refill this cycle; the accepted word must not be offered twice.
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pobieranie_rozkazow.sv
// ---------------------------------------------------------------------------
// tb_pobieranie_rozkazow
// Directed checks of reset, streaming, backpressure, jump, halt, reset
// during halt and PC wrap, followed by a randomized run scored against an
// instruction-stream model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_pobieranie_rozkazow;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_a;
    logic [15:0] rom_d;
    logic        skok;
    logic [7:0]  skok_adr;
    logic        stop;
    logic [15:0] ir;
    logic [7:0]  pc_ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        zatrzymany;

    // Second instance: reset address near the top of the space, free running.
    logic        rst2_n;
    logic [7:0]  rom_a2;
    logic [15:0] rom_d2;
    logic [15:0] ir2;
    logic [7:0]  pc_ir2;
    logic        ir_valid2;
    logic        zatrzymany2;

    int n_cmp = 0;
    int n_err = 0;

    // Program ROM contents.
    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a < 8'd4) return 16'h1001 + {8'h00, a};
        return {a ^ 8'h5A, a};
    endfunction

    // Jump target as seen by the program.
    function automatic logic [7:0] tgt(input logic [7:0] pcir, input logic [7:0] adr);
`ifdef POBIERANIE_SKOK_WZGL_EN
        return pcir + adr;
`else
        return adr;
`endif
    endfunction

    assign rom_d  = rom_word(rom_a);
    assign rom_d2 = rom_word(rom_a2);

    pobieranie_rozkazow dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_a      (rom_a),
        .rom_d      (rom_d),
        .skok       (skok),
        .skok_adr   (skok_adr),
        .stop       (stop),
        .ir         (ir),
        .pc_ir      (pc_ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .zatrzymany (zatrzymany)
    );

    pobieranie_rozkazow #(.RESET_ADDR(8'hFE)) dut_fe (
        .clk        (clk),
        .rst_n      (rst2_n),
        .rom_a      (rom_a2),
        .rom_d      (rom_d2),
        .skok       (1'b0),
        .skok_adr   (8'h00),
        .stop       (1'b0),
        .ir         (ir2),
        .pc_ir      (pc_ir2),
        .ir_valid   (ir_valid2),
        .ir_ready   (1'b1),
        .zatrzymany (zatrzymany2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instruction-stream scoreboard ----------------
    // exp_next is the address of the next instruction decode should see.
    logic        mon_on = 1'b0;
    logic        p_ok   = 1'b0;
    logic [7:0]  exp_next;
    logic        p_valid, p_ready, p_skok, p_stop, p_halt;
    logic [15:0] p_ir;
    logic [7:0]  p_pcir, p_adr;

    always @(negedge clk) begin
        if (!mon_on) begin
            p_ok = 1'b0;
        end else begin
            if (p_ok) begin
                if (p_valid && p_ready) begin
                    check("acc_pc", p_pcir, exp_next);
                    check("acc_ir", p_ir, rom_word(p_pcir));
                    exp_next = p_pcir + 8'd1;
                end
                if (p_skok) exp_next = tgt(p_pcir, p_adr);
                check("halt_flag", zatrzymany, p_stop);
                if (p_valid && !p_ready && !p_skok) begin
                    check("hold_valid", ir_valid, 1);
                    check("hold_ir", ir, p_ir);
                    check("hold_pc", pc_ir, p_pcir);
                end else if (p_skok || p_stop || p_halt) begin
                    check("no_fetch", ir_valid, 0);
                end else begin
                    check("fetch_valid", ir_valid, 1);
                    check("fetch_pc", pc_ir, exp_next);
                    check("fetch_ir", ir, rom_word(exp_next));
                end
            end
            p_valid = ir_valid;
            p_ready = ir_ready;
            p_skok  = skok;
            p_stop  = stop;
            p_halt  = zatrzymany;
            p_ir    = ir;
            p_pcir  = pc_ir;
            p_adr   = skok_adr;
            p_ok    = 1'b1;
        end
    end

    // ---------------- directed sequence + random run ----------------
    logic [7:0] adr, cel, nxt, cel2, wrap;

    initial begin
        rst_n = 1'b0; skok = 1'b0; skok_adr = 8'h00; stop = 1'b0;
        ir_ready = 1'b0; rst2_n = 1'b0;
        step();
        step();

        // Reset values.
        check("rst_rom_a", rom_a, 0);
        check("rst_ir", ir, 0);
        check("rst_pc_ir", pc_ir, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_halt", zatrzymany, 0);

        // Stream ROM[0..2] back to back.
        rst_n = 1'b1; ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_ir", ir, 16'h1001 + i);
            check("stream_pc", pc_ir, i);
            check("stream_valid", ir_valid, 1);
        end

        // Backpressure while ROM[2] is presented.
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ir", ir, 16'h1003);
            check("bp_pc", pc_ir, 2);
            check("bp_rom_a", rom_a, 3);
            check("bp_valid", ir_valid, 1);
        end
        ir_ready = 1'b1;
        step();
        check("bp_resume_ir", ir, 16'h1004);
        check("bp_resume_pc", pc_ir, 3);
        step();
        check("seq4_pc", pc_ir, 4);
        step();
        check("seq5_pc", pc_ir, 5);
        check("seq5_ir", ir, rom_word(8'd5));

        // Jump from pc_ir = 5.
`ifdef POBIERANIE_SKOK_WZGL_EN
        adr = 8'hFE;
`else
        adr = 8'h40;
`endif
        cel = tgt(8'd5, adr);
        skok = 1'b1; skok_adr = adr;
        step();
        skok = 1'b0;
        check("jmp_bubble", ir_valid, 0);
        check("jmp_rom_a", rom_a, cel);
        step();
        check("jmp_valid", ir_valid, 1);
        check("jmp_pc", pc_ir, cel);
        check("jmp_ir", ir, rom_word(cel));

        // Halt for 4 cycles with decode ready.
        nxt = cel + 8'd1;
        stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("halt_flag_on", zatrzymany, 1);
            check("halt_valid", ir_valid, 0);
            check("halt_rom_a", rom_a, nxt);
        end
        stop = 1'b0;
        step();
        check("unhalt_flag", zatrzymany, 0);
        check("unhalt_valid", ir_valid, 0);
        step();
        check("resume_valid", ir_valid, 1);
        check("resume_pc", pc_ir, nxt);
        check("resume_ir", ir, rom_word(nxt));

        // Jump and halt together, then reset while halted.
        cel2 = tgt(nxt, 8'h80);
        stop = 1'b1; skok = 1'b1; skok_adr = 8'h80;
        step();
        skok = 1'b0;
        check("sj_halt", zatrzymany, 1);
        check("sj_rom_a", rom_a, cel2);
        check("sj_valid", ir_valid, 0);
        step();
        check("sj_hold_rom_a", rom_a, cel2);
        check("sj_hold_halt", zatrzymany, 1);
        rst_n = 1'b0; skok = 1'b1; skok_adr = 8'h11;
        step();
        check("rst2_rom_a", rom_a, 0);
        check("rst2_ir", ir, 0);
        check("rst2_pc_ir", pc_ir, 0);
        check("rst2_valid", ir_valid, 0);
        check("rst2_halt", zatrzymany, 0);
        skok = 1'b0; stop = 1'b0;

        // PC wrap on the instance reset to 0xFE.
        check("wrap_rst_rom_a", rom_a2, 8'hFE);
        rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            wrap = 8'hFE + 8'(i);
            check("wrap_pc", pc_ir2, wrap);
            check("wrap_ir", ir2, rom_word(wrap));
            check("wrap_valid", ir_valid2, 1);
        end

        // Randomized run against the stream scoreboard.
        exp_next = 8'h00;
        rst_n = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            skok     = ($urandom_range(0, 15) == 0);
            skok_adr = 8'($urandom);
            if ($urandom_range(0, 9) == 0) stop = !stop;
            step();
        end
        mon_on = 1'b0;
        skok = 1'b0; stop = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
